// File: rtl/hazard_forward_unit_pkg.sv
// Shared processor package for the hazard/forwarding logic.
// Holds the EX operand-mux select encodings used by the forwarding unit.
package hazard_forward_unit_pkg;

  // Select values for the 3-input EX operand mux; 2'b11 is never produced
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEMWB   = 2'b01,
    FWD_EXMEM   = 2'b10
  } fwd_sel_e;

  localparam int STALL_COUNT_BITS = 32;

endpackage

// File: rtl/hazard_forward_unit_fwd_compare.sv
// Per-operand comparator: EX/MEM match, MEM/WB match and load-use match.
// One instance serves operand A (Rs), a second serves operand B (Rt).
module fwd_compare
  import hazard_forward_unit_pkg::*;
#(
  parameter int ADDR_BITS = 4
) (
  input  logic [ADDR_BITS:0] idex_src,
  input  logic [ADDR_BITS:0] id_src,
  input  logic [ADDR_BITS:0] exmem_dest,
  input  logic               exmem_regwrite,
  input  logic [ADDR_BITS:0] memwb_dest,
  input  logic               memwb_regwrite,
  input  logic [ADDR_BITS:0] idex_dest,
  input  logic               idex_memread,
  output fwd_sel_e           fwd_sel,
  output logic               load_use
);

  // Pick the youngest in-flight producer; register 0 is hardwired and never forwarded
  always_comb begin
    fwd_sel = FWD_REGFILE;
    if (exmem_regwrite && (exmem_dest != '0) && (exmem_dest == idex_src)) begin
      fwd_sel = FWD_EXMEM;
    end else if (memwb_regwrite && (memwb_dest != '0) && (memwb_dest == idex_src)) begin
      fwd_sel = FWD_MEMWB;
    end
  end

  // A load in EX whose result the instruction in ID needs cannot be forwarded in time
  assign load_use = idex_memread && (idex_dest != '0) && (idex_dest == id_src);

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding unit for a 5-stage pipeline.
// Tracks ID/EX, EX/MEM and MEM/WB register-number state, drives the EX
// operand forward selects and a one-cycle load-use stall.
// Optional feature: define HAZARD_STALL_COUNT_EN to add a 32-bit StallCount output.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int ADDR_BITS = 4
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [ADDR_BITS:0]   IdRs,
  input  logic [ADDR_BITS:0]   IdRt,
  input  logic [ADDR_BITS:0]   IdDest,
  input  logic                 IdRegWrite,
  input  logic                 IdMemRead,
  input  logic                 Flush,
  output logic [1:0]           ForwardA,
  output logic [1:0]           ForwardB,
  output logic                 Stall
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [STALL_COUNT_BITS-1:0] StallCount
`endif
);

  logic [ADDR_BITS:0] idex_rs;
  logic [ADDR_BITS:0] idex_rt;
  logic [ADDR_BITS:0] idex_dest;
  logic               idex_regwrite;
  logic               idex_memread;
  logic [ADDR_BITS:0] exmem_dest;
  logic               exmem_regwrite;
  logic [ADDR_BITS:0] memwb_dest;
  logic               memwb_regwrite;

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;
  logic     load_use_a;
  logic     load_use_b;
  logic     load_id;

  fwd_compare #(.ADDR_BITS(ADDR_BITS)) u_cmp_a (
    .idex_src       (idex_rs),
    .id_src         (IdRs),
    .exmem_dest     (exmem_dest),
    .exmem_regwrite (exmem_regwrite),
    .memwb_dest     (memwb_dest),
    .memwb_regwrite (memwb_regwrite),
    .idex_dest      (idex_dest),
    .idex_memread   (idex_memread),
    .fwd_sel        (fwd_a),
    .load_use       (load_use_a)
  );

  fwd_compare #(.ADDR_BITS(ADDR_BITS)) u_cmp_b (
    .idex_src       (idex_rt),
    .id_src         (IdRt),
    .exmem_dest     (exmem_dest),
    .exmem_regwrite (exmem_regwrite),
    .memwb_dest     (memwb_dest),
    .memwb_regwrite (memwb_regwrite),
    .idex_dest      (idex_dest),
    .idex_memread   (idex_memread),
    .fwd_sel        (fwd_b),
    .load_use       (load_use_b)
  );

  assign ForwardA = fwd_a;
  assign ForwardB = fwd_b;
  // Flush kills the consumer anyway, so it overrides a load-use stall
  assign Stall    = (load_use_a || load_use_b) && !Flush;
  assign load_id  = !Stall && !Flush;

  // ID/EX takes the decoded instruction, or a bubble on stall/flush
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_dest     <= '0;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
    end else if (load_id) begin
      idex_rs       <= IdRs;
      idex_rt       <= IdRt;
      idex_dest     <= IdDest;
      idex_regwrite <= IdRegWrite;
      idex_memread  <= IdMemRead;
    end else begin
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_dest     <= '0;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
    end
  end

  // Later stages always advance, stall or not, so the load drains on schedule
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      exmem_dest     <= '0;
      exmem_regwrite <= 1'b0;
      memwb_dest     <= '0;
      memwb_regwrite <= 1'b0;
    end else begin
      exmem_dest     <= idex_dest;
      exmem_regwrite <= idex_regwrite;
      memwb_dest     <= exmem_dest;
      memwb_regwrite <= exmem_regwrite;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  // Count stalled cycles; wraps naturally at the counter width
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      StallCount <= '0;
    end else if (Stall) begin
      StallCount <= StallCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: a per-cycle vector table
// plus a hand-written asynchronous reset in the middle of a stall.
module tb_hazard_forward_unit;

  logic       Clk;
  logic       Reset_n;
  logic [4:0] IdRs;
  logic [4:0] IdRt;
  logic [4:0] IdDest;
  logic       IdRegWrite;
  logic       IdMemRead;
  logic       Flush;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       Stall;
`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] StallCount;
`endif

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       fl;
    logic [1:0] expFa;
    logic [1:0] expFb;
    logic       expStall;
  } vec_t;

  vec_t vecs[$];
  int   numChecks = 0;
  int   numErrors = 0;
  int   expStallCount = 0;

  hazard_forward_unit dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .IdRs       (IdRs),
    .IdRt       (IdRt),
    .IdDest     (IdDest),
    .IdRegWrite (IdRegWrite),
    .IdMemRead  (IdMemRead),
    .Flush      (Flush),
    .ForwardA   (ForwardA),
    .ForwardB   (ForwardB),
    .Stall      (Stall)
`ifdef HAZARD_STALL_COUNT_EN
    ,
    .StallCount (StallCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One row = one cycle of ID-stage inputs plus the outputs expected that cycle
  task automatic addVec(input int rs, input int rt, input int dest, input bit rw,
                        input bit mr, input bit fl, input int fa, input int fb,
                        input bit st);
    vec_t v;
    v.rs = 5'(rs);
    v.rt = 5'(rt);
    v.dest = 5'(dest);
    v.rw = rw;
    v.mr = mr;
    v.fl = fl;
    v.expFa = 2'(fa);
    v.expFb = 2'(fb);
    v.expStall = st;
    vecs.push_back(v);
  endtask

  task automatic addNop(input int fa, input int fb);
    addVec(0, 0, 0, 1'b0, 1'b0, 1'b0, fa, fb, 1'b0);
  endtask

  // Drive the ID inputs just after a falling edge, then let them settle
  task automatic applyStimulus(input vec_t v);
    @(negedge Clk);
    IdRs       = v.rs;
    IdRt       = v.rt;
    IdDest     = v.dest;
    IdRegWrite = v.rw;
    IdMemRead  = v.mr;
    Flush      = v.fl;
    #1;
  endtask

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] actual, input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s row %0d got %0h expected %0h", name, row, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ForwardA"}, -1, 32'(ForwardA), 32'd0);
    checkOutput({tag, "_ForwardB"}, -1, 32'(ForwardB), 32'd0);
    checkOutput({tag, "_Stall"}, -1, 32'(Stall), 32'd0);
`ifdef HAZARD_STALL_COUNT_EN
    checkOutput({tag, "_StallCount"}, -1, StallCount, 32'd0);
`endif
  endtask

  initial begin
    IdRs = '0; IdRt = '0; IdDest = '0;
    IdRegWrite = 1'b0; IdMemRead = 1'b0; Flush = 1'b0;
    Reset_n = 1'b0;

    // add $3 ; sub uses $3 as Rs -> EX/MEM forward on A only
    addVec(1, 2, 3, 1, 0, 0, 0, 0, 0);
    addVec(3, 6, 4, 1, 0, 0, 0, 0, 0);
    addNop(2, 0);
    addNop(0, 0); addNop(0, 0);
    // producer $5, unrelated, consumer $5 on Rt -> MEM/WB forward on B
    addVec(1, 2, 5, 1, 0, 0, 0, 0, 0);
    addVec(1, 2, 6, 1, 0, 0, 0, 0, 0);
    addVec(9, 5, 10, 1, 0, 0, 0, 0, 0);
    addNop(0, 1);
    addNop(0, 0); addNop(0, 0);
    // two writes of $7 back to back -> EX/MEM wins on both operands
    addVec(1, 2, 7, 1, 0, 0, 0, 0, 0);
    addVec(2, 1, 7, 1, 0, 0, 0, 0, 0);
    addVec(7, 7, 8, 1, 0, 0, 0, 0, 0);
    addNop(2, 2);
    addNop(0, 0); addNop(0, 0);
    // EX/MEM matches but does not write -> falls back to MEM/WB
    addVec(0, 0, 11, 1, 0, 0, 0, 0, 0);
    addVec(1, 2, 11, 0, 0, 0, 0, 0, 0);
    addVec(11, 3, 12, 1, 0, 0, 0, 0, 0);
    addNop(1, 0);
    addNop(0, 0); addNop(0, 0);
    // lw $8 ; add uses $8 as Rs -> one stall cycle, then MEM/WB forward
    addVec(1, 0, 8, 1, 1, 0, 0, 0, 0);
    addVec(8, 2, 9, 1, 0, 0, 0, 0, 1);
    addVec(8, 2, 9, 1, 0, 0, 0, 0, 0);
    addNop(1, 0);
    addNop(0, 0); addNop(0, 0);
    // lw $13 ; consumer uses $13 as Rt
    addVec(0, 0, 13, 1, 1, 0, 0, 0, 0);
    addVec(3, 13, 14, 1, 0, 0, 0, 0, 1);
    addVec(3, 13, 14, 1, 0, 0, 0, 0, 0);
    addNop(0, 1);
    addNop(0, 0); addNop(0, 0);
    // load-use with Flush in the same cycle -> no stall, consumer becomes a bubble
    addVec(0, 0, 8, 1, 1, 0, 0, 0, 0);
    addVec(8, 8, 9, 1, 0, 1, 0, 0, 0);
    addNop(0, 0);
    addNop(0, 0); addNop(0, 0);
    // flushed producer must not be forwarded from
    addVec(1, 2, 6, 1, 0, 1, 0, 0, 0);
    addVec(6, 0, 7, 1, 0, 0, 0, 0, 0);
    addNop(0, 0);
    addNop(0, 0); addNop(0, 0);
    // write to $0 never forwards
    addVec(1, 2, 0, 1, 0, 0, 0, 0, 0);
    addVec(0, 0, 3, 1, 0, 0, 0, 0, 0);
    addNop(0, 0);
    addNop(0, 0);
    // load to $0 never stalls
    addVec(0, 0, 0, 1, 1, 0, 0, 0, 0);
    addVec(0, 5, 4, 1, 0, 0, 0, 0, 0);
    addNop(0, 0);
    addNop(0, 0);

    // Outputs must be idle while reset is held
    repeat (2) @(posedge Clk);
    #1;
    checkAllZero("in_reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    checkAllZero("after_release");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput("ForwardA", i, 32'(ForwardA), 32'(vecs[i].expFa));
      checkOutput("ForwardB", i, 32'(ForwardB), 32'(vecs[i].expFb));
      checkOutput("Stall", i, 32'(Stall), 32'(vecs[i].expStall));
`ifdef HAZARD_STALL_COUNT_EN
      checkOutput("StallCount", i, StallCount, 32'(expStallCount));
`endif
      if (vecs[i].expStall) expStallCount++;
    end

    // Reset mid-stall: producer $3, lw $8 reading $3, consumer of $8
    begin
      vec_t v;
      v.rs = 5'd1; v.rt = 5'd2; v.dest = 5'd3; v.rw = 1'b1; v.mr = 1'b0; v.fl = 1'b0;
      v.expFa = 2'd0; v.expFb = 2'd0; v.expStall = 1'b0;
      applyStimulus(v);
      v.rs = 5'd3; v.rt = 5'd0; v.dest = 5'd8; v.mr = 1'b1;
      applyStimulus(v);
      v.rs = 5'd8; v.rt = 5'd0; v.dest = 5'd9; v.mr = 1'b0;
      applyStimulus(v);
      checkOutput("pre_reset_Stall", -1, 32'(Stall), 32'd1);
      checkOutput("pre_reset_ForwardA", -1, 32'(ForwardA), 32'd2);
      #1;
      Reset_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      @(posedge Clk);
      #1;
      checkAllZero("reset_held");
      @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      checkAllZero("reset_released");
    end

    $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
    $finish;
  end

endmodule
